// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, the
// default parameter values and the counter width helper.
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    HOLD       = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    REL_IC     = 3'd3,
    REL_PERIPH = 3'd4,
    RUN        = 3'd5
  } seq_state_t;

  localparam int DEF_SYNC_STAGES        = 2;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_STAGE_GAP          = 16;

  // The counter has to reach max(a, b) - 1. A 1-bit floor keeps the vector
  // legal when both timers are a single cycle long.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Lock status, restart request and staged reset outputs of the sequencer.
//   locked              clock-wizard lock status (asynchronous to clk_200)
//   sw_rst              one-cycle software restart request
//   interconnect_resetn active-low interconnect reset, released first
//   peripheral_resetn   active-low datapath reset, released second
//   ready               sequence complete
//   lock_loss_cnt       saturating count of lock losses
// slave is the sequencer's view, master the view of whoever drives it.
interface reset_sequencer_if;
  logic       locked;
  logic       sw_rst;
  logic       interconnect_resetn;
  logic       peripheral_resetn;
  logic       ready;
  logic [7:0] lock_loss_cnt;

  modport master (
    output locked, sw_rst,
    input  interconnect_resetn, peripheral_resetn, ready, lock_loss_cnt
  );

  modport slave (
    input  locked, sw_rst,
    output interconnect_resetn, peripheral_resetn, ready, lock_loss_cnt
  );
endinterface

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit.
//   clk  destination clock
//   clr  asynchronous active-high clear of every stage
//   d    asynchronous input
//   q    synchronized output, SYNC_STAGES edges behind d
module bit_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_ff;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) sync_ff <= '0;
    else     sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
  end

  assign q = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release after clock-wizard lock.
//   clk_200  clock-wizard output clock
//   reset    asynchronous active-high reset
//   seq      lock/restart inputs, staged resets, ready and lock-loss count
//
// state      | meaning
// HOLD       | just out of reset, everything held
// WAIT_LOCK  | all resets asserted, waiting for synchronized lock
// STABLE     | lock seen, counting LOCK_STABLE_CYCLES of continuous lock
// REL_IC     | interconnect released, waiting STAGE_GAP
// REL_PERIPH | peripherals released, waiting STAGE_GAP
// RUN        | sequence complete
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int STAGE_GAP          = DEF_STAGE_GAP
) (
  input logic              clk_200,
  input logic              reset,
  reset_sequencer_if.slave seq
);

  localparam int CNT_W = cnt_width(LOCK_STABLE_CYCLES, STAGE_GAP);
  localparam logic [CNT_W-1:0] LOCK_TC = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             locked_s;
  logic             lock_lost;
  logic             ic_resetn_q, periph_resetn_q, ready_q;
  logic [7:0]       lock_loss_cnt_q;

  bit_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk_200),
    .clr (reset),
    .d   (seq.locked),
    .q   (locked_s)
  );

  always_ff @(posedge clk_200 or posedge reset) begin
    if (reset) begin
      state           <= HOLD;
      cnt             <= '0;
      ic_resetn_q     <= 1'b0;
      periph_resetn_q <= 1'b0;
      ready_q         <= 1'b0;
      lock_loss_cnt_q <= 8'd0;
    end else begin
      state <= state_nxt;
      // Saturate so idle states never wrap back onto a terminal count.
      if (state_nxt != state)  cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      // Decoded from the next state so the outputs move on the same edge.
      ic_resetn_q     <= (state_nxt == REL_IC) || (state_nxt == REL_PERIPH) ||
                         (state_nxt == RUN);
      periph_resetn_q <= (state_nxt == REL_PERIPH) || (state_nxt == RUN);
      ready_q         <= (state_nxt == RUN);
      if (lock_lost && lock_loss_cnt_q != 8'hFF)
        lock_loss_cnt_q <= lock_loss_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    lock_lost = 1'b0;
    case (state)
      HOLD:      state_nxt = WAIT_LOCK;
      WAIT_LOCK: if (locked_s) state_nxt = STABLE;
      default: begin
        // Lock loss wins over both sw_rst and a terminal count, so a
        // combined event is counted exactly once and never releases.
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          lock_lost = 1'b1;
        end else if (seq.sw_rst && state != STABLE) begin
          state_nxt = WAIT_LOCK;
        end else begin
          case (state)
            STABLE:     if (cnt == LOCK_TC) state_nxt = REL_IC;
            REL_IC:     if (cnt == GAP_TC)  state_nxt = REL_PERIPH;
            REL_PERIPH: if (cnt == GAP_TC)  state_nxt = RUN;
            default:    state_nxt = state;
          endcase
        end
      end
    endcase
  end

  assign seq.interconnect_resetn = ic_resetn_q;
  assign seq.peripheral_resetn   = periph_resetn_q;
  assign seq.ready               = ready_q;
  assign seq.lock_loss_cnt       = lock_loss_cnt_q;

endmodule
